// File: rtl/fp_add_sub_pipe.sv
// Four-stage pipelined IEEE-754 adder/subtractor with four rounding modes,
// special-value handling, per-result exception flags and valid/ready flow control.
//
// Flow control: adv = !out_valid | out_ready, and in_ready = adv. An operation
// transfers in on in_valid & in_ready and a result transfers out on
// out_valid & out_ready. Every stage register, bubbles included, moves only
// when adv is high, so a stalled consumer freezes the whole pipe and keeps
// result/flags stable.
module fp_add_sub_pipe #(
  parameter int  EXP_BITS  = 8,
  parameter int  MANT_BITS = 23,
  localparam int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             operation_select,
  input  logic [1:0]       round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  // Aligned mantissa is {hidden, frac, G, R, S}.
  localparam int MW  = MANT_BITS + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam int EW  = EXP_BITS + 2;

  localparam logic [EXP_BITS-1:0] EXP_ONES = '1;
  localparam logic [EXP_BITS-1:0] EXP_MAXF = EXP_ONES - 1'b1;
  localparam logic [EXP_BITS-1:0] D_MAX    = EXP_BITS'(MW - 1);
  localparam logic [WIDTH-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_BITS-1){1'b0}}};

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  function automatic logic [LZW-1:0] count_lz(input logic [MW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = '0;
    found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- S1
  logic                sa, sb_eff;
  logic [EXP_BITS-1:0] ea, eb;
  logic [MANT_BITS-1:0] fa, fb;

  assign sa     = a[WIDTH-1];
  assign sb_eff = b[WIDTH-1] ^ operation_select;
  assign ea     = a[WIDTH-2:MANT_BITS];
  assign eb     = b[WIDTH-2:MANT_BITS];
  assign fa     = a[MANT_BITS-1:0];
  assign fb     = b[MANT_BITS-1:0];

  logic                 a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_ge;
  logic [MANT_BITS:0]   ma, mb;
  logic                 sx_d, sy_d, spec_d;
  logic [EXP_BITS-1:0]  ex_d, ey_d, d_d;
  logic [MANT_BITS:0]   mx_d, my_d;
  logic [WIDTH-1:0]     spec_res_d;
  logic [3:0]           spec_flags_d;

  // Classify operands, flush subnormals, order by magnitude, resolve specials.
  always_comb begin
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_snan = a_nan && !fa[MANT_BITS-1];
    b_snan = b_nan && !fb[MANT_BITS-1];
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    ma     = (ea == '0) ? '0 : {1'b1, fa};
    mb     = (eb == '0) ? '0 : {1'b1, fb};
    a_ge   = {ea, ma} >= {eb, mb};
    if (a_ge) begin
      sx_d = sa;     ex_d = ea; mx_d = ma;
      sy_d = sb_eff; ey_d = eb; my_d = mb;
    end else begin
      sx_d = sb_eff; ex_d = eb; mx_d = mb;
      sy_d = sa;     ey_d = ea; my_d = ma;
    end
    d_d          = ex_d - ey_d;
    spec_d       = 1'b0;
    spec_res_d   = '0;
    spec_flags_d = 4'b0000;
    if (a_nan || b_nan) begin
      spec_d       = 1'b1;
      spec_res_d   = QNAN;
      spec_flags_d = {a_snan || b_snan, 3'b000};
    end else if (a_inf && b_inf && (sa != sb_eff)) begin
      spec_d       = 1'b1;
      spec_res_d   = QNAN;
      spec_flags_d = 4'b1000;
    end else if (a_inf) begin
      spec_d     = 1'b1;
      spec_res_d = {sa, EXP_ONES, {MANT_BITS{1'b0}}};
    end else if (b_inf) begin
      spec_d     = 1'b1;
      spec_res_d = {sb_eff, EXP_ONES, {MANT_BITS{1'b0}}};
    end
  end

  logic                s1_v, s1_sx, s1_sy, s1_spec;
  logic [1:0]          s1_rm;
  logic [EXP_BITS-1:0] s1_ex, s1_d;
  logic [MANT_BITS:0]  s1_mx, s1_my;
  logic [WIDTH-1:0]    s1_spec_res;
  logic [3:0]          s1_spec_flags;

  // S1 register: unpacked, swapped operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v          <= in_valid;
      s1_rm         <= round_mode;
      s1_sx         <= sx_d;
      s1_sy         <= sy_d;
      s1_ex         <= ex_d;
      s1_mx         <= mx_d;
      s1_my         <= my_d;
      s1_d          <= d_d;
      s1_spec       <= spec_d;
      s1_spec_res   <= spec_res_d;
      s1_spec_flags <= spec_flags_d;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [MW-1:0] y_ext, y_al;
  logic          lost;

  // Right-align the smaller operand, folding shifted-out bits into sticky.
  always_comb begin
    y_ext = {s1_my, 3'b000};
    y_al  = '0;
    lost  = 1'b0;
    if (s1_d >= D_MAX) begin
      y_al = {{(MW-1){1'b0}}, |s1_my};
    end else begin
      lost = |(y_ext & ~({MW{1'b1}} << s1_d));
      y_al = (y_ext >> s1_d) | {{(MW-1){1'b0}}, lost};
    end
  end

  logic                s2_v, s2_sx, s2_same, s2_spec;
  logic [1:0]          s2_rm;
  logic [EXP_BITS-1:0] s2_ex;
  logic [MW-1:0]       s2_x, s2_y;
  logic [WIDTH-1:0]    s2_spec_res;
  logic [3:0]          s2_spec_flags;

  // S2 register: aligned mantissas.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else if (adv) begin
      s2_v          <= s1_v;
      s2_rm         <= s1_rm;
      s2_sx         <= s1_sx;
      s2_same       <= (s1_sx == s1_sy);
      s2_ex         <= s1_ex;
      s2_x          <= {s1_mx, 3'b000};
      s2_y          <= y_al;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;
    end
  end

  // ---------------------------------------------------------------- S3
  logic [MW:0]    sum_d;
  logic [LZW-1:0] lzc_d;

  // Magnitude add or subtract; X >= Y so the difference is never negative.
  always_comb begin
    if (s2_same) sum_d = {1'b0, s2_x} + {1'b0, s2_y};
    else         sum_d = {1'b0, s2_x} - {1'b0, s2_y};
    lzc_d = count_lz(sum_d[MW-1:0]);
  end

  logic                s3_v, s3_sx, s3_same, s3_spec;
  logic [1:0]          s3_rm;
  logic [EXP_BITS-1:0] s3_ex;
  logic [MW:0]         s3_sum;
  logic [LZW-1:0]      s3_lzc;
  logic [WIDTH-1:0]    s3_spec_res;
  logic [3:0]          s3_spec_flags;

  // S3 register: raw sum and its leading-zero count.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v <= 1'b0;
    end else if (adv) begin
      s3_v          <= s2_v;
      s3_rm         <= s2_rm;
      s3_sx         <= s2_sx;
      s3_same       <= s2_same;
      s3_ex         <= s2_ex;
      s3_sum        <= sum_d;
      s3_lzc        <= lzc_d;
      s3_spec       <= s2_spec;
      s3_spec_res   <= s2_spec_res;
      s3_spec_flags <= s2_spec_flags;
    end
  end

  // ---------------------------------------------------------------- S4
  logic [EW-1:0]        exp_w, exp_n, exp_r;
  logic [MW-1:0]        norm;
  logic [MANT_BITS:0]   mant;
  logic [MANT_BITS+1:0] mant_r;
  logic [MANT_BITS-1:0] frac_r;
  logic                 g, r, st, up, zero_sign;
  logic [WIDTH-1:0]     res_d, inf_res, max_res;
  logic [3:0]           flags_d;

  // Normalise, round, detect overflow/underflow and pack.
  always_comb begin
    exp_w = {2'b00, s3_ex};
    if (s3_sum[MW]) begin
      norm  = s3_sum[MW:1] | {{(MW-1){1'b0}}, s3_sum[0]};
      exp_n = exp_w + EW'(1);
    end else begin
      norm  = s3_sum[MW-1:0] << s3_lzc;
      exp_n = exp_w - EW'(s3_lzc);
    end
    mant = norm[MW-1:3];
    g    = norm[2];
    r    = norm[1];
    st   = norm[0];
    case (s3_rm)
      RM_RNE:  up = g && (r || st || mant[0]);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = s3_sx && (g || r || st);
      RM_RUP:  up = !s3_sx && (g || r || st);
      default: up = 1'b0;
    endcase
    mant_r    = {1'b0, mant} + {{(MANT_BITS+1){1'b0}}, up};
    exp_r     = exp_n + {{(EW-1){1'b0}}, mant_r[MANT_BITS+1]};
    frac_r    = mant_r[MANT_BITS+1] ? mant_r[MANT_BITS:1] : mant_r[MANT_BITS-1:0];
    inf_res   = {s3_sx, EXP_ONES, {MANT_BITS{1'b0}}};
    max_res   = {s3_sx, EXP_MAXF, {MANT_BITS{1'b1}}};
    zero_sign = s3_same ? s3_sx : (s3_rm == RM_RDN);
    res_d     = '0;
    flags_d   = 4'b0000;
    if (s3_spec) begin
      res_d   = s3_spec_res;
      flags_d = s3_spec_flags;
    end else if (s3_sum == '0) begin
      res_d = {zero_sign, {(WIDTH-1){1'b0}}};
    end else if (exp_n[EW-1] || (exp_n == '0)) begin
      res_d   = {s3_sx, {(WIDTH-1){1'b0}}};
      flags_d = 4'b0011;
    end else if (exp_r >= {2'b00, EXP_ONES}) begin
      flags_d = 4'b0101;
      case (s3_rm)
        RM_RNE:  res_d = inf_res;
        RM_RTZ:  res_d = max_res;
        RM_RDN:  res_d = s3_sx ? inf_res : max_res;
        default: res_d = s3_sx ? max_res : inf_res;
      endcase
    end else begin
      res_d   = {s3_sx, exp_r[EXP_BITS-1:0], frac_r};
      flags_d = {3'b000, g || r || st};
    end
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
    end else if (adv) begin
      out_valid <= s3_v;
      if (s3_v) begin
        result <= res_d;
        flags  <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Self-checking bench for fp_add_sub_pipe (binary32 configuration).
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        operation_select;
  logic [1:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [35:0] exp_q[$];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [1:0]  rm;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  fp_add_sub_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .operation_select(operation_select), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    operation_select = 1'b0; round_mode = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h, required 00000000", result); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b, required 0000", flags); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_latency();
    int lat;
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h40000000; operation_select = 1'b0; round_mode = 2'b00;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL lat_cycles: got %0d, required 4", lat); end
    n_checks++; if (result !== 32'h40400000) begin n_fail++; $display("FAIL lat_result: got %h, required 40400000", result); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL lat_flags: got %b, required 0000", flags); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t vecs[$];
    vecs.push_back({32'h3F800000, 32'h40000000, 1'b0, 2'b00, 32'h40400000, 4'b0000});
    vecs.push_back({32'h3F800000, 32'h3F800000, 1'b1, 2'b00, 32'h00000000, 4'b0000});
    vecs.push_back({32'h3F800000, 32'h3F800000, 1'b1, 2'b10, 32'h80000000, 4'b0000});
    vecs.push_back({32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 4'b0001});
    vecs.push_back({32'h3F800000, 32'h33800000, 1'b0, 2'b11, 32'h3F800001, 4'b0001});
    vecs.push_back({32'h3F800000, 32'h33800000, 1'b0, 2'b01, 32'h3F800000, 4'b0001});
    vecs.push_back({32'h3F800001, 32'h33800000, 1'b0, 2'b00, 32'h3F800002, 4'b0001});
    vecs.push_back({32'hBF800000, 32'hB3800000, 1'b0, 2'b10, 32'hBF800001, 4'b0001});
    vecs.push_back({32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 4'b0101});
    vecs.push_back({32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 32'h7F7FFFFF, 4'b0101});
    vecs.push_back({32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b10, 32'h7F7FFFFF, 4'b0101});
    vecs.push_back({32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b10, 32'hFF800000, 4'b0101});
    vecs.push_back({32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b11, 32'hFF7FFFFF, 4'b0101});
    vecs.push_back({32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000, 4'b1000});
    vecs.push_back({32'h7FA00000, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'b1000});
    vecs.push_back({32'h7FC00001, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'b0000});
    vecs.push_back({32'h7F800000, 32'h3F800000, 1'b0, 2'b00, 32'h7F800000, 4'b0000});
    vecs.push_back({32'h3F800000, 32'h7F800000, 1'b1, 2'b00, 32'hFF800000, 4'b0000});
    vecs.push_back({32'h80000000, 32'h80000000, 1'b0, 2'b11, 32'h80000000, 4'b0000});
    vecs.push_back({32'h00000001, 32'h3F800000, 1'b0, 2'b00, 32'h3F800000, 4'b0000});
    vecs.push_back({32'h00800000, 32'h00C00000, 1'b1, 2'b00, 32'h80000000, 4'b0011});
    out_ready = 1'b1;
    fork
      begin : drive
        for (int i = 0; i < vecs.size(); i++) begin
          logic acc;
          int   cyc;
          a = vecs[i].a; b = vecs[i].b; operation_select = vecs[i].op; round_mode = vecs[i].rm;
          in_valid = 1'b1;
          acc = 1'b0; cyc = 0;
          while (!acc && cyc < 50) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; cyc++;
          end
          if (acc) exp_q.push_back({vecs[i].res, vecs[i].fl});
          else begin n_checks++; n_fail++; $display("FAIL vec_accept_timeout: op %0d not accepted", i); end
        end
        in_valid = 1'b0;
      end
      begin : collect
        int got;
        int cyc;
        logic [35:0] e;
        got = 0; cyc = 0;
        while (got < vecs.size() && cyc < 400) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL vec_extra: got %h/%b, required no output", result, flags);
            end else begin
              e = exp_q.pop_front();
              if ({result, flags} !== e) begin
                n_fail++; $display("FAIL vec_%0d: got %h/%b, required %h/%b", got, result, flags, e[35:4], e[3:0]);
              end
            end
            got++;
          end
          @(posedge clk); #1; cyc++;
        end
        if (got < vecs.size()) begin n_checks++; n_fail++; $display("FAIL vec_timeout: got %0d results, required %0d", got, vecs.size()); end
      end
    join
  endtask

  task automatic test_back_to_back();
    vec_t vecs[$];
    logic saw_stall;
    saw_stall = 1'b0;
    vecs.push_back({32'h3F800000, 32'h3F800000, 1'b0, 2'b00, 32'h40000000, 4'b0000});
    vecs.push_back({32'h40000000, 32'h3F800000, 1'b0, 2'b00, 32'h40400000, 4'b0000});
    vecs.push_back({32'h40400000, 32'h3F800000, 1'b1, 2'b00, 32'h40000000, 4'b0000});
    vecs.push_back({32'h3FC00000, 32'h3E800000, 1'b0, 2'b00, 32'h3FE00000, 4'b0000});
    vecs.push_back({32'h40800000, 32'h3F800000, 1'b1, 2'b00, 32'h40400000, 4'b0000});
    vecs.push_back({32'h3F000000, 32'h3F000000, 1'b0, 2'b00, 32'h3F800000, 4'b0000});
    vecs.push_back({32'hC0000000, 32'h3F800000, 1'b0, 2'b00, 32'hBF800000, 4'b0000});
    vecs.push_back({32'h41200000, 32'h40200000, 1'b1, 2'b00, 32'h40F00000, 4'b0000});
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin : drive
        for (int i = 0; i < 8; i++) begin
          logic acc;
          int   cyc;
          a = vecs[i].a; b = vecs[i].b; operation_select = vecs[i].op; round_mode = vecs[i].rm;
          in_valid = 1'b1;
          acc = 1'b0; cyc = 0;
          while (!acc && cyc < 50) begin
            @(negedge clk); acc = in_ready; if (!in_ready) saw_stall = 1'b1;
            @(posedge clk); #1; cyc++;
          end
          if (acc) exp_q.push_back({vecs[i].res, vecs[i].fl});
          else begin n_checks++; n_fail++; $display("FAIL b2b_accept_timeout: op %0d not accepted", i); end
        end
        in_valid = 1'b0;
      end
      begin : collect
        int got;
        int cyc;
        logic [35:0] e;
        logic [35:0] held;
        logic held_v;
        got = 0; cyc = 0; held_v = 1'b0; held = '0;
        while (got < 8 && cyc < 200) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra: got %h/%b, required no output", result, flags);
            end else begin
              e = exp_q.pop_front();
              if ({result, flags} !== e) begin
                n_fail++; $display("FAIL b2b_%0d: got %h/%b, required %h/%b", got, result, flags, e[35:4], e[3:0]);
              end
            end
            got++;
          end
          if (out_valid && !out_ready) begin
            if (held_v) begin
              n_checks++;
              if ({result, flags} !== held) begin
                n_fail++; $display("FAIL b2b_stable: got %h/%b, required %h/%b", result, flags, held[35:4], held[3:0]);
              end
            end
            held = {result, flags}; held_v = 1'b1;
          end else begin
            held_v = 1'b0;
          end
          @(posedge clk); #1; cyc++;
          out_ready = !(cyc >= 3 && cyc < 8);
        end
        if (got < 8) begin n_checks++; n_fail++; $display("FAIL b2b_timeout: got %0d results, required 8", got); end
      end
    join
    out_ready = 1'b1;
    n_checks++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop: got %b, required 1", saw_stall); end
    begin
      logic extra;
      extra = 1'b0;
      repeat (6) begin @(negedge clk); if (out_valid) extra = 1'b1; end
      n_checks++; if (extra !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra: got %b, required 0", extra); end
    end
  endtask

  task automatic test_reset_mid_flight();
    logic seen;
    int   lat;
    @(posedge clk); #1;
    out_ready = 1'b1;
    operation_select = 1'b0; round_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      a = 32'h3F800000; b = 32'h3F800000;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b, required 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b, required 1", in_ready); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flushed: got %b, required 0", seen); end
    @(posedge clk); #1;
    a = 32'h3F800000; b = 32'h3F800000; operation_select = 1'b1; round_mode = 2'b10;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rst_post_latency: got %0d, required 4", lat); end
    n_checks++; if (result !== 32'h80000000) begin n_fail++; $display("FAIL rst_post_result: got %h, required 80000000", result); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
